// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a one-entry skid buffer, flush, and stall/flush statistics.
// in_ready is registered, so no combinational path runs from out_ready back to in_ready.
module pipe_stage_reg #(
    parameter int DATA_W     = 128,
    parameter int CTRL_W     = 8,
    parameter int CLEAR_DATA = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic              xfer_in;
    logic              xfer_out;

    assign out_valid = (state != EMPTY);
    assign xfer_in   = in_valid & in_ready;
    assign xfer_out  = out_valid & out_ready;
    assign occupancy = state;
    // Control bits read as a NOP whenever nothing is presented, even if main still holds a stale entry.
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign out_data  = main_data;

    // NOTE: every register, including the wide payload, is reset so a mid-run reset leaves no stale entry visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b0;
            main_ctrl <= '0;
            skid_ctrl <= '0;
            main_data <= '0;
            skid_data <= '0;
        end else if (flush) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            main_ctrl <= '0;
            skid_ctrl <= '0;
            if (CLEAR_DATA != 0) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let the FULL branch read the old skid while refilling main.
            in_ready <= 1'b1;
            case (state)
                EMPTY: begin
                    if (xfer_in) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (xfer_in && xfer_out) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end else if (xfer_in) begin
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                        state     <= FULL;
                        in_ready  <= 1'b0;
                    end else if (xfer_out) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        main_ctrl <= skid_ctrl;
                        main_data <= skid_data;
                        state     <= ONE;
                    end else begin
                        in_ready <= 1'b0;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 128, width of the held datapath payload (PC, operand values, immediates, tags).
REQ-002 Parameter CTRL_W, default 8, width of the control-bit vector (WB/MEM enables, branch, S, etc.).
REQ-003 Parameter CLEAR_DATA, default 1; 1 = flush zeroes data registers, 0 = flush leaves data unchanged.
REQ-004 Parameter CNT_W, default 16, width of each statistics counter.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 flush  input  1  synchronous kill of all held entries.
REQ-008 in_valid  input  1  upstream entry offered.
REQ-009 in_ready  output  1  stage can accept an entry this cycle.
REQ-010 in_ctrl  input  CTRL_W  upstream control bits.
REQ-011 in_data  input  DATA_W  upstream payload.
REQ-012 out_valid  output  1  head entry presented downstream.
REQ-013 out_ready  input  1  downstream consumes head entry.
REQ-014 out_ctrl  output  CTRL_W  head control bits; all-zero (NOP) whenever out_valid=0.
REQ-015 out_data  output  DATA_W  head payload.
REQ-016 occupancy  output  2  number of held entries, 0..2.
REQ-017 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.
REQ-018 flush_cnt  output  CNT_W  cycles with flush=1.

Function
REQ-019 Storage is a main register plus one skid register; states EMPTY (occupancy 0), ONE (1), FULL (2).
REQ-020 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-021 in_ready is a registered output: 1 in EMPTY and ONE, 0 in FULL; no combinational path from out_ready to in_ready.
REQ-022 out_valid = 1 in ONE and FULL; out_ctrl/out_data always come from the main register.
REQ-023 EMPTY: transfer in -> main <= in, go ONE; else stay.
REQ-024 ONE: in & out -> main <= in, stay ONE; in only -> skid <= in, go FULL; out only -> go EMPTY; neither -> hold.
REQ-025 FULL: out_ready=1 -> main <= skid, go ONE; else hold both registers.
REQ-026 Latency: entry accepted in cycle N appears on out_* in cycle N+1 when stage was EMPTY or main was consumed in N; throughput one entry per cycle sustained.
REQ-027 Order preserved: entries leave in acceptance order; no entry dropped or duplicated except by flush.
REQ-028 flush=1: next state EMPTY, main and skid control bits zeroed, data zeroed iff CLEAR_DATA=1; any transfer in during that cycle is discarded; in_ready=1 next cycle.
REQ-029 flush takes priority over every handshake event in the same cycle.
REQ-030 stall_cnt +1 each cycle out_valid=1 & out_ready=0; saturates at 2^CNT_W-1; not cleared by flush.
REQ-031 flush_cnt +1 each cycle flush=1; saturates at 2^CNT_W-1.
REQ-032 Downstream toggling out_ready while out_valid=1 shall not alter out_data/out_ctrl until a transfer out occurs.

Reset
REQ-033 rst=0 asynchronously forces state EMPTY, in_ready=0 while asserted, all ctrl/data registers 0, out_valid=0, occupancy=0, stall_cnt=0, flush_cnt=0.
REQ-034 First rising clk edge after rst deassertion sets in_ready=1; no transfer is accepted during reset.
REQ-035 Reset asserted mid-operation (any state, counters non-zero) discards all entries immediately, without waiting for clk.

Verification
REQ-036 Stream: out_ready=1, in_valid=1 for 8 cycles, data 1..8 -> out_data 1..8 on consecutive cycles starting 1 cycle later, occupancy stays 1, stall_cnt=0.
REQ-037 Backpressure: accept A,B with out_ready=0 -> occupancy=2, in_ready=0, out_data=A held; raise out_ready -> A then B, stall_cnt equals stalled cycles.
REQ-038 Flush while FULL with in_valid=1 (entry C) -> next cycle out_valid=0, out_ctrl=0, occupancy=0, C never appears, flush_cnt=1; CLEAR_DATA=0 build keeps out_data unchanged.
REQ-039 Saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15.
REQ-040 Async reset mid-FULL between clock edges -> all outputs 0 immediately; after release one edge -> in_ready=1, occupancy=0.
REQ-041 Random in_valid/out_ready/flush for 10k cycles against a queue model -> zero order/loss mismatches, occupancy never exceeds 2.
